// File: rtl/serial_subtractor.sv
// ---------------------------------------------------------------------------
// serial_subtractor
//   Bit-serial subtractor computing diff = a - b - bin, one bit per clock,
//   LSB first. A single full-subtractor stage is iterated WIDTH times under a
//   three-state FSM (IDLE -> SHIFT -> DONE -> IDLE). Results are registered
//   on the edge that leaves DONE, together with a one-cycle done pulse.
//
// Ports
//   clk    in   1      rising-edge clock
//   rst    in   1      synchronous, active-high reset
//   start  in   1      operation request, sampled only while ready=1
//   a      in   WIDTH  minuend, captured on an accepted start
//   b      in   WIDTH  subtrahend, captured on an accepted start
//   bin    in   1      borrow-in, captured on an accepted start
//   ready  out  1      high in IDLE (combinational from state)
//   busy   out  1      high in SHIFT (combinational from state)
//   done   out  1      one-cycle pulse; result outputs valid from then on
//   diff   out  WIDTH  result, modulo 2^WIDTH, held until the next result
//   bout   out  1      borrow-out from the MSB (unsigned a < b + bin)
//   ovf    out  1      signed overflow of the subtraction
//   zero   out  1      diff == 0
// ---------------------------------------------------------------------------
module serial_subtractor #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             ready,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             bout,
    output logic             ovf,
    output logic             zero
);

    localparam int CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } state_e;

    state_e state_q, state_d;

    logic [WIDTH-1:0] a_sr_q, a_sr_d;
    logic [WIDTH-1:0] b_sr_q, b_sr_d;
    logic [WIDTH-1:0] res_q,  res_d;
    logic             br_q,   br_d;
    logic [CNT_W-1:0] cnt_q,  cnt_d;
    logic             a_msb_q, a_msb_d;
    logic             b_msb_q, b_msb_d;
    logic [WIDTH-1:0] diff_q, diff_d;
    logic             bout_q, bout_d;
    logic             ovf_q,  ovf_d;
    logic             zero_q, zero_d;
    logic             done_q, done_d;

    // Full-subtractor stage on the current LSBs of the operand shift registers.
    logic ai, bi, d_bit, br_next;
    assign ai      = a_sr_q[0];
    assign bi      = b_sr_q[0];
    assign d_bit   = ai ^ bi ^ br_q;
    assign br_next = (~ai & bi) | (~(ai ^ bi) & br_q);

    // ---------------- FSM: state register ----------------
    // NOTE: sequential state is updated only with non-blocking assignments so
    // every register samples the pre-edge values of the others.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ---------------- FSM: next-state logic ----------------
    // NOTE: the default assignment before the case keeps this block free of
    // inferred latches on paths that do not change state.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE:  if (start) state_d = S_SHIFT;
            S_SHIFT: if (cnt_q == CNT_LAST) state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // ---------------- FSM: outputs decoded from state ----------------
    always_comb begin
        ready = (state_q == S_IDLE);
        busy  = (state_q == S_SHIFT);
    end

    // ---------------- Datapath next-state ----------------
    always_comb begin
        a_sr_d  = a_sr_q;
        b_sr_d  = b_sr_q;
        res_d   = res_q;
        br_d    = br_q;
        cnt_d   = cnt_q;
        a_msb_d = a_msb_q;
        b_msb_d = b_msb_q;
        diff_d  = diff_q;
        bout_d  = bout_q;
        ovf_d   = ovf_q;
        zero_d  = zero_q;
        // The pulse is registered on the edge leaving DONE, aligned with the
        // result registers loading.
        done_d  = (state_q == S_DONE);

        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    a_sr_d  = a;
                    b_sr_d  = b;
                    br_d    = bin;
                    cnt_d   = '0;
                    a_msb_d = a[WIDTH-1];
                    b_msb_d = b[WIDTH-1];
                end
            end
            S_SHIFT: begin
                a_sr_d = a_sr_q >> 1;
                b_sr_d = b_sr_q >> 1;
                br_d   = br_next;
                // Enter at the MSB so the first (LSB) bit ends up at bit 0
                // after WIDTH shifts.
                res_d  = {d_bit, res_q[WIDTH-1:1]};
                cnt_d  = cnt_q + CNT_W'(1);
            end
            S_DONE: begin
                diff_d = res_q;
                bout_d = br_q;
                ovf_d  = (a_msb_q != b_msb_q) && (res_q[WIDTH-1] != a_msb_q);
                zero_d = (res_q == '0);
            end
            default: ;
        endcase
    end

    // ---------------- Datapath registers ----------------
    always_ff @(posedge clk) begin
        if (rst) begin
            a_sr_q  <= '0;
            b_sr_q  <= '0;
            res_q   <= '0;
            br_q    <= 1'b0;
            cnt_q   <= '0;
            a_msb_q <= 1'b0;
            b_msb_q <= 1'b0;
            diff_q  <= '0;
            bout_q  <= 1'b0;
            ovf_q   <= 1'b0;
            zero_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            a_sr_q  <= a_sr_d;
            b_sr_q  <= b_sr_d;
            res_q   <= res_d;
            br_q    <= br_d;
            cnt_q   <= cnt_d;
            a_msb_q <= a_msb_d;
            b_msb_q <= b_msb_d;
            diff_q  <= diff_d;
            bout_q  <= bout_d;
            ovf_q   <= ovf_d;
            zero_q  <= zero_d;
            done_q  <= done_d;
        end
    end

    assign done = done_q;
    assign diff = diff_q;
    assign bout = bout_q;
    assign ovf  = ovf_q;
    assign zero = zero_q;

endmodule
